// File: rtl/dht11_sensor_model.sv
// dht11_sensor_model: sensor-side DHT11 responder sending a programmable 40-bit reading
// after a host start pulse, with optional checksum corruption.
module dht11_sensor_model #(
  parameter int START_MIN = 900000,
  parameter int RESP_WAIT = 1500,
  parameter int RESP_LOW  = 4000,
  parameter int RESP_HIGH = 4000,
  parameter int BIT_LOW   = 2500,
  parameter int BIT0_HIGH = 1300,
  parameter int BIT1_HIGH = 3500
) (
  input  logic       clk,
  input  logic       rst,
  inout  wire        dht11_io,
  input  logic [7:0] hum_int,
  input  logic [7:0] hum_dec,
  input  logic [7:0] temp_int,
  input  logic [7:0] temp_dec,
  input  logic       corrupt_chk,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frames_sent
);
  typedef enum logic [2:0] {
    S_IDLE, S_RESP_DELAY, S_RESP_LOW, S_RESP_HIGH, S_BIT_LOW, S_BIT_HIGH, S_END_LOW
  } state_t;
  state_t      state;
  logic [19:0] cnt;
  logic [19:0] lim;
  logic [5:0]  bit_idx;
  logic [39:0] frame;
  logic [7:0]  chk;
  logic        line_m;
  logic        line_s;
  logic        drv_low;
  logic        expire;
  assign dht11_io = drv_low ? 1'b0 : 1'bz;
  assign chk = (hum_int + hum_dec + temp_int + temp_dec) ^ {7'd0, corrupt_chk};
  // Terminal count of the current timed state; every state lasts lim+1 cycles.
  assign lim = state == S_RESP_DELAY ? 20'(RESP_WAIT - 1) :
               state == S_RESP_LOW   ? 20'(RESP_LOW - 1) :
               state == S_RESP_HIGH  ? 20'(RESP_HIGH - 1) :
               state == S_BIT_HIGH   ? (frame[bit_idx] ? 20'(BIT1_HIGH - 1) : 20'(BIT0_HIGH - 1)) :
                                       20'(BIT_LOW - 1);
  assign expire = cnt == lim;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      frame       <= '0;
      line_m      <= 1'b1;
      line_s      <= 1'b1;
      drv_low     <= 1'b0;
      busy        <= 1'b0;
      frame_done  <= 1'b0;
      frames_sent <= '0;
    end else begin
      line_m     <= dht11_io;
      line_s     <= line_m;
      frame_done <= 1'b0;
      if (state == S_IDLE) begin
        cnt <= line_s ? '0 : (&cnt ? cnt : cnt + 20'd1);
        if (line_s && cnt >= 20'(START_MIN)) begin
          frame <= {chk, temp_dec, temp_int, hum_dec, hum_int};
          busy  <= 1'b1;
          state <= S_RESP_DELAY;
        end
      end else if (!expire) begin
        cnt <= cnt + 20'd1;
      end else begin
        cnt <= '0;
        case (state)
          S_RESP_DELAY: begin state <= S_RESP_LOW;  drv_low <= 1'b1; end
          S_RESP_LOW:   begin state <= S_RESP_HIGH; drv_low <= 1'b0; end
          S_RESP_HIGH:  begin state <= S_BIT_LOW;   drv_low <= 1'b1; bit_idx <= '0; end
          S_BIT_LOW:    begin state <= S_BIT_HIGH;  drv_low <= 1'b0; end
          S_BIT_HIGH: begin
            state   <= bit_idx == 6'd39 ? S_END_LOW : S_BIT_LOW;
            bit_idx <= bit_idx == 6'd39 ? bit_idx : bit_idx + 6'd1;
            drv_low <= 1'b1;
          end
          default: begin
            state       <= S_IDLE;
            drv_low     <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b1;
            frames_sent <= frames_sent + 8'd1;
          end
        endcase
      end
    end
  end
endmodule
